// File: rtl/lutram_write_sched_pkg.sv
// lutram_write_sched_pkg: shared FSM state type, pointer-width helper and packed-slice macro
`ifndef LWS_SLICE
`define LWS_SLICE(bus, k, w) bus[(k)*(w) +: (w)]
`endif
package lutram_write_sched_pkg;
  typedef enum logic {CLR, RUN} state_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lutram_write_sched_rr_pick.sv
// lutram_write_sched_rr_pick: round-robin pick of the first request at or after ptr
//   req  in  N   request vector
//   ptr  in  PW  search start index (always < N)
//   gnt  out N   one-hot grant (zero when no request)
//   idx  out PW  encoded index of the granted request
module lutram_write_sched_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic found;
  int j;
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end
endmodule

// File: rtl/lutram_write_sched.sv
// lutram_write_sched: clear sweep then round-robin write-port arbitration for a LUT register file
//   CLK, RST_N            clock, async active-low reset
//   CLEAR                 restart clear sweep from lo
//   REQ/REQ_ADDR/REQ_DATA per-requester write requests, packed k*width
//   GNT                   combinational one-hot accept
//   INIT_DONE             high when no sweep is running
//   WE/ADDR_IN/D_IN       registered write port to the register file
module lutram_write_sched
  import lutram_write_sched_pkg::*;
#(
  parameter int                  N_REQ      = 3,
  parameter int                  addr_width = 1,
  parameter int                  data_width = 1,
  parameter int                  lo         = 0,
  parameter int                  hi         = 1,
  parameter logic [data_width-1:0] INIT_VAL = '0
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          CLEAR,
  input  logic [N_REQ-1:0]              REQ,
  input  logic [N_REQ*addr_width-1:0]   REQ_ADDR,
  input  logic [N_REQ*data_width-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]              GNT,
  output logic                          INIT_DONE,
  output logic                          WE,
  output logic [addr_width-1:0]         ADDR_IN,
  output logic [data_width-1:0]         D_IN
);
  localparam int PW = ptr_w(N_REQ);
  state_t state, state_nx;
  logic [addr_width-1:0] clr_cnt, clr_nx, addr_nx;
  logic [data_width-1:0] d_nx;
  logic [PW-1:0] rr_ptr, ptr_nx, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic we_nx, done_nx;
  lutram_write_sched_rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
    .req(REQ),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign GNT = (state == RUN && !CLEAR) ? pick_gnt : '0;
  // CLEAR edge issues no write; the restarted sweep begins at lo on the following edge.
  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    ptr_nx   = rr_ptr;
    we_nx    = 1'b0;
    addr_nx  = ADDR_IN;
    d_nx     = D_IN;
    done_nx  = INIT_DONE;
    if (CLEAR) begin
      state_nx = CLR;
      clr_nx   = addr_width'(lo);
      done_nx  = 1'b0;
    end else if (state == CLR) begin
      we_nx   = 1'b1;
      addr_nx = clr_cnt;
      d_nx    = INIT_VAL;
      clr_nx  = clr_cnt + 1'b1;
      if (clr_cnt == addr_width'(hi)) begin
        state_nx = RUN;
        done_nx  = 1'b1;
      end
    end else if (|pick_gnt) begin
      we_nx   = 1'b1;
      addr_nx = `LWS_SLICE(REQ_ADDR, pick_idx, addr_width);
      d_nx    = `LWS_SLICE(REQ_DATA, pick_idx, data_width);
      ptr_nx  = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= CLR;
      clr_cnt   <= addr_width'(lo);
      rr_ptr    <= '0;
      WE        <= 1'b0;
      ADDR_IN   <= '0;
      D_IN      <= '0;
      INIT_DONE <= 1'b0;
    end else begin
      state     <= state_nx;
      clr_cnt   <= clr_nx;
      rr_ptr    <= ptr_nx;
      WE        <= we_nx;
      ADDR_IN   <= addr_nx;
      D_IN      <= d_nx;
      INIT_DONE <= done_nx;
    end
  end
endmodule
